rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter N_REQ, 3, number of write-back requesters (0=ALU, 1=MEM, 2=MULDIV).
REQ-002 Parameter DATA_W, 16, register data width.
REQ-003 Parameter ADDR_W, 4, register address width (16 registers).
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 HOLD  input  1  pipeline stall; no grants while high.
REQ-007 REQ_VALID  input  N_REQ  per-requester write request.
REQ-008 REQ_ADDR  input  N_REQ*ADDR_W  per-requester destination address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 REQ_DATA  input  N_REQ*DATA_W  per-requester write data, packed as REQ_ADDR.
REQ-010 REQ_READY  output  N_REQ  combinational grant; write accepted when REQ_VALID[i] and REQ_READY[i] are both high.
REQ-011 WRITE_ENABLE  output  2  registered register-file write enables; bit0 = port 1, bit1 = port 2.
REQ-012 WRITE_ADDRESS1, WRITE_ADDRESS2  output  ADDR_W  registered port addresses.
REQ-013 WRITE_DATA1, WRITE_DATA2  output  DATA_W  registered port data.
REQ-014 CONFLICT  output  1  registered; high for one cycle after a same-address request was deferred.

Function
REQ-015 The arbiter SHALL grant at most two requests per cycle, and none while HOLD=1.
REQ-016 The first granted request in priority order SHALL drive port 1 and the second SHALL drive port 2.
REQ-017 A single grant SHALL use port 1 only (WRITE_ENABLE=01).
REQ-018 A candidate whose REQ_ADDR equals the port-1 grant address SHALL NOT be granted that cycle; the search SHALL continue to the next candidate, and CONFLICT SHALL assert next cycle.
REQ-019 Requests SHALL be granted on cycle N and appear on the write ports on cycle N+1 (1-cycle latency).
REQ-020 In a cycle with no grant, WRITE_ENABLE SHALL be 00 on the next cycle; address/data outputs SHALL hold their previous values.
REQ-021 Ungranted requests SHALL stay pending; requesters hold REQ_ADDR/REQ_DATA stable until accepted.
REQ-022 A priority pointer SHALL select the highest-priority requester; after any grant it SHALL move to the requester following the last granted one, modulo N_REQ.
REQ-023 The pointer SHALL be unchanged in cycles with no grant.
REQ-024 REQ_READY SHALL be a pure function of REQ_VALID, REQ_ADDR, HOLD, RST and the pointer, and SHALL NOT depend on REQ_DATA.

Reset
REQ-025 While RST=1 at a clock edge: WRITE_ENABLE=00, WRITE_ADDRESS1/2=0, WRITE_DATA1/2=0, CONFLICT=0, pointer=0.
REQ-026 While RST=1, REQ_READY SHALL be all zero; RST asserted mid-stream SHALL drop grants without completing them.

Configuration
REQ-027 With RF_ARB_ROUND_ROBIN_EN defined, the pointer SHALL rotate per REQ-022.
REQ-028 Without RF_ARB_ROUND_ROBIN_EN, priority SHALL be fixed at ALU > MEM > MULDIV and no pointer register SHALL exist.

Structure
REQ-029 Package rf_pkg SHALL hold DATA_W/ADDR_W defaults, requester index constants (REQ_ALU, REQ_MEM, REQ_MULDIV) and the write-port record typedef.
REQ-030 A sub-module rf_arb_pick SHALL combinationally select up to two indices from a rotated valid vector, with address-conflict masking.

Verification
REQ-031 Reset then ALU only, addr 0xA, data 0xFFFF -> READY=001; next cycle WRITE_ENABLE=01, ADDR1=0xA, DATA1=0xFFFF.
REQ-032 ALU(0xB, 0xFFFF) and MEM(0x0, 0xABCD) together -> WRITE_ENABLE=11, ADDR1=0xB, ADDR2=0x0, DATA2=0xABCD.
REQ-033 All three valid, distinct addresses, round-robin enabled, pointer 0 -> cycle 1 grants ALU+MEM; cycle 2 grants MULDIV first, then ALU.
REQ-034 ALU and MEM both to address 0x5 -> only ALU granted; CONFLICT=1 next cycle; MEM written on the following cycle.
REQ-035 HOLD=1 with all requests valid for 3 cycles -> READY=000, WRITE_ENABLE=00, pointer unchanged; HOLD low -> grants resume.
REQ-036 RST asserted while requests are pending -> outputs zero on the next edge; no write issued for the dropped requests.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults, requester indices and write-port record for the register-file write arbiter.
package rf_pkg;

    localparam int RF_N_REQ  = 3;
    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;

    localparam int REQ_ALU    = 0;
    localparam int REQ_MEM    = 1;
    localparam int REQ_MULDIV = 2;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_port_t;

    // (a + b) mod n for operands already below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rf_arb_pick.sv
// Picks the first two set entries of a priority-ordered valid vector (index 0 highest);
// the second pick skips any entry aimed at the same address as the first.
module rf_arb_pick #(
    parameter int N      = 3,
    parameter int ADDR_W = 4,
    parameter int IW     = 2
) (
    input  logic [N-1:0]             valid,
    input  logic [N-1:0][ADDR_W-1:0] addr,
    output logic                     first_vld,
    output logic [IW-1:0]            first_idx,
    output logic                     second_vld,
    output logic [IW-1:0]            second_idx,
    output logic                     conflict
);

    logic [ADDR_W-1:0] first_addr;

    always_comb begin
        first_vld  = 1'b0;
        first_idx  = '0;
        first_addr = '0;
        second_vld = 1'b0;
        second_idx = '0;
        conflict   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
                if (!first_vld) begin
                    first_vld  = 1'b1;
                    first_idx  = IW'(i);
                    first_addr = addr[i];
                end else if (!second_vld) begin
                    // Same-address candidates are deferred and the search keeps going.
                    if (addr[i] == first_addr) begin
                        conflict = 1'b1;
                    end else begin
                        second_vld = 1'b1;
                        second_idx = IW'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-port register-file write-back arbiter. Define RF_ARB_ROUND_ROBIN_EN for a rotating
// priority pointer; otherwise priority is fixed ALU > MEM > MULDIV.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int N_REQ  = RF_N_REQ,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [1:0]              write_enable,
    output logic [ADDR_W-1:0]       write_address1,
    output logic [ADDR_W-1:0]       write_address2,
    output logic [DATA_W-1:0]       write_data1,
    output logic [DATA_W-1:0]       write_data2,
    output logic                    conflict
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]                  ptr;
    logic [N_REQ-1:0]               valid_rot;
    logic [N_REQ-1:0][ADDR_W-1:0]   addr_rot;
    logic                           first_vld, second_vld, pick_conflict;
    logic [IW-1:0]                  first_idx, second_idx;
    logic [IW-1:0]                  idx1, idx2;
    logic                           grant_en, g1, g2;
    wr_port_t                       sel1, sel2;
    wr_port_t                       port1, port2;

    // Rotate so that the pointer's requester lands at priority slot 0.
    always_comb begin
        int src;
        valid_rot = '0;
        addr_rot  = '0;
        src       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            src          = wrap_add(k, int'(ptr), N_REQ);
            valid_rot[k] = req_valid[src];
            addr_rot[k]  = req_addr[src*ADDR_W +: ADDR_W];
        end
    end

    rf_arb_pick #(
        .N      (N_REQ),
        .ADDR_W (ADDR_W),
        .IW     (IW)
    ) u_pick (
        .valid      (valid_rot),
        .addr       (addr_rot),
        .first_vld  (first_vld),
        .first_idx  (first_idx),
        .second_vld (second_vld),
        .second_idx (second_idx),
        .conflict   (pick_conflict)
    );

    assign grant_en = !hold && !rst;
    assign g1       = grant_en && first_vld;
    assign g2       = grant_en && second_vld;
    assign idx1     = IW'(wrap_add(int'(first_idx), int'(ptr), N_REQ));
    assign idx2     = IW'(wrap_add(int'(second_idx), int'(ptr), N_REQ));

    always_comb begin
        req_ready = '0;
        if (g1) req_ready[idx1] = 1'b1;
        if (g2) req_ready[idx2] = 1'b1;
    end

    always_comb begin
        sel1.addr = req_addr[int'(idx1)*ADDR_W +: ADDR_W];
        sel1.data = req_data[int'(idx1)*DATA_W +: DATA_W];
        sel2.addr = req_addr[int'(idx2)*ADDR_W +: ADDR_W];
        sel2.data = req_data[int'(idx2)*DATA_W +: DATA_W];
    end

    // Address/data registers only load on a grant so idle cycles keep the last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_enable <= 2'b00;
            port1        <= '0;
            port2        <= '0;
            conflict     <= 1'b0;
        end else begin
            write_enable <= {g2, g1};
            conflict     <= g1 && pick_conflict;
            if (g1) port1 <= sel1;
            if (g2) port2 <= sel2;
        end
    end

`ifdef RF_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (g1) begin
            ptr <= IW'(wrap_add(int'(g2 ? idx2 : idx1), 1, N_REQ));
        end
    end
`else
    assign ptr = '0;
`endif

    assign write_address1 = port1.addr;
    assign write_data1    = port1.data;
    assign write_address2 = port2.addr;
    assign write_data2    = port2.data;

endmodule
